// File: rtl/prog_clk_divider.sv
// Programmable clock divider: one counter yields a per-period tick and a
// registered square wave; ratio changes are deferred to the period boundary.
module prog_clk_divider #(
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = 524288
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ract_q, ract_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] div_clamp;
    logic             last;
    logic             wrap;
    logic             apply;

    assign half      = ract_q >> 1;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign div_clamp = (div_in < CNT_W'(2)) ? CNT_W'(2) : div_in;
    assign last      = (cnt_q == ract_q - CNT_W'(1));
    assign wrap      = en & last;
    // Boundary where a pending ratio may be swapped in without a glitch.
    assign apply     = wrap | sync_clr | (busy_q & ~en);

    always_comb begin
        cnt_d  = cnt_q;
        ract_d = ract_q;
        pend_d = pend_q;
        busy_d = busy_q;
        clk_d  = clk_q;
        if (apply) begin
            cnt_d  = '0;
            clk_d  = 1'b1;
            busy_d = 1'b0;
            if (div_wr) begin
                ract_d = div_clamp;
            end else if (busy_q) begin
                ract_d = pend_q;
            end
        end else begin
            if (en) begin
                cnt_d = cnt_inc;
                clk_d = (cnt_inc < half);
            end
            if (div_wr) begin
                pend_d = div_clamp;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            ract_q <= DefDiv;
            pend_q <= '0;
            busy_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ract_q <= ract_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            clk_q  <= clk_d;
        end
    end

    assign tick    = wrap;
    assign clk_out = clk_q;
    assign busy    = busy_q;
    assign cnt_o   = cnt_q;

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Fully synchronous, programmable clock divider and tick generator. Successor to the fixed ripple divide-by-2^19 chain.
- A single counter in the system clock domain produces:
  - a one-cycle clock-enable tick per period;
  - a registered near-50% square wave.
- The divide ratio can be changed at run time, glitch-free: a new ratio takes effect only at the period boundary.
- Feeds display-scan, debounce and slow-FSM logic elsewhere in the project.

Parameters:
- CNT_W, 20, counter and divisor width in bits.
- DEFAULT_DIV, 524288, divide ratio active out of reset (2^19). Must be in 2..2^CNT_W-1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; when low the counter holds.
- sync_clr  input  1  synchronous restart of the period.
- div_wr  input  1  one-cycle strobe; captures div_in as the pending ratio.
- div_in  input  CNT_W  requested divide ratio R.
- tick  output  1  high for one cycle at the last count of each period.
- clk_out  output  1  registered square wave, period R cycles.
- busy  output  1  a pending ratio is waiting to be applied.
- cnt_o  output  CNT_W  current count, for debug.

Behaviour:
- Reset (rst=0, async):
  - cnt=0, active ratio R_act=DEFAULT_DIV, pending ratio=0, busy=0, clk_out=0.
  - tick is combinational from cnt/en, so it is 0 in reset because cnt=0 and R_act≥2.
- Ratio clamp: a written div_in of 0 or 1 is stored as 2. Every other value is stored unchanged.
- Half period: H = R_act >> 1, i.e. floor(R_act/2). clk_out is high for H cycles and low for R_act−H cycles. An odd R gives the longer low phase.
- tick = en & (cnt == R_act−1). Combinational, zero latency from cnt.
- Counting, en=1:
  - If cnt == R_act−1, then cnt→0 (wrap). Otherwise cnt→cnt+1.
  - clk_out is registered as (cnt_next < H) on the same edge.
- en=0: cnt and clk_out hold, tick=0.
- Writes:
  - div_wr=1 loads the pending ratio (clamped) and sets busy=1 on the next edge.
  - A second div_wr while busy overwrites the pending value; the last write wins.
- Apply point: the pending ratio becomes R_act, and busy clears, on the edge where any of the following holds:
  - (a) the counter wraps;
  - (b) sync_clr=1;
  - (c) busy=1 and en=0.
  - In all three cases cnt→0 and clk_out→(0 < H_new)=1.
  - On that edge, tick and clk_out for the current cycle use the old ratio.
- Write coinciding with an apply point: if div_wr coincides with any apply point, the newly written value is the one applied; busy stays 0 after that edge.
- sync_clr=1 with busy=0: cnt→0, clk_out→1. This takes priority over en and over the wrap.
- Mid-operation reset returns immediately to the reset state; any pending ratio is discarded.
- First period after reset: cnt starts at 0 with clk_out=0, so the first high phase is H−1 cycles (documented, accepted). Use sync_clr to align if exact phase is needed.
- No combinational path from any input to clk_out or cnt_o. tick depends on en combinationally.

Test Plan:
- Reset with DEFAULT_DIV=8 (override), then en=1 for 24 cycles:
  - tick at cnt=7, every 8 cycles;
  - after the first period clk_out is 4 cycles high / 4 low;
  - cnt_o sequence 0..7.
- Write div_in=5 at cnt=2 of an R=8 period:
  - busy=1 until the wrap;
  - the old period completes as 8 cycles with tick at cnt=7;
  - next periods are 5 cycles, clk_out 2 high / 3 low;
  - busy=0 after the wrap.
- Write div_in=0, then div_in=1:
  - both stored as 2; tick every 2 cycles, clk_out toggles every cycle;
  - back-to-back writes 6 then 9 before the wrap → 9 applied.
- en=0 at cnt=3 for 10 cycles with busy=0: cnt_o=3 and clk_out held, tick=0 throughout; resuming with en=1 continues from 4. Repeat with busy=1 and en=0: the ratio applies on the next edge and cnt→0.
- sync_clr at cnt=6 with R=8 and a pending ratio of 3 (busy=1): next cnt=0, clk_out=1, R_act=3, busy=0, no tick on that cycle.
- Assert rst low mid-period at cnt=5 with busy=1:
  - immediately cnt=0, clk_out=0, busy=0, R_act=DEFAULT_DIV;
  - the pending value is never applied after release.
